// File: rtl/ika2151_timer.sv
// Timer A / Timer B of the IKA2151: sample-rate counters with overflow flags,
// active-low IRQ and the CSM key-on strobe driven by Timer A overflows.
module ika2151_timer (
  input  logic       i_EMUCLK,
  input  logic       i_MRST_n,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CYCLE_31,
  input  logic [9:0] i_TA_VAL,
  input  logic [7:0] i_TB_VAL,
  input  logic       i_LOAD_A,
  input  logic       i_LOAD_B,
  input  logic       i_IRQEN_A,
  input  logic       i_IRQEN_B,
  input  logic       i_FRST_A,
  input  logic       i_FRST_B,
  input  logic       i_CSM,
  output logic       o_TIMERA_FLAG,
  output logic       o_TIMERB_FLAG,
  output logic       o_IRQ_n,
  output logic       o_CSM_KEYON
);

  logic [9:0] cnt_a;
  logic [7:0] cnt_b;
  logic [3:0] pre_b;
  logic       lda_d, ldb_d;

  logic tick, sample_tick;
  logic start_a, start_b, step_a, step_b, ovf_a, ovf_b;

  assign tick        = ~i_phi1_NCEN_n;
  assign sample_tick = tick & i_CYCLE_31;

  // A start suppresses any coincident step, so it also suppresses the overflow.
  assign start_a = tick & i_LOAD_A & ~lda_d;
  assign start_b = tick & i_LOAD_B & ~ldb_d;
  assign step_a  = sample_tick & i_LOAD_A & ~start_a;
  assign step_b  = sample_tick & (pre_b == 4'hF) & i_LOAD_B & ~start_b;
  assign ovf_a   = step_a & (cnt_a == 10'h3FF);
  assign ovf_b   = step_b & (cnt_b == 8'hFF);

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cnt_a         <= 10'd0;
      cnt_b         <= 8'd0;
      pre_b         <= 4'd0;
      lda_d         <= 1'b0;
      ldb_d         <= 1'b0;
      o_TIMERA_FLAG <= 1'b0;
      o_TIMERB_FLAG <= 1'b0;
      o_CSM_KEYON   <= 1'b0;
    end else if (tick) begin
      lda_d <= i_LOAD_A;
      ldb_d <= i_LOAD_B;

      if (start_a || ovf_a) cnt_a <= i_TA_VAL;
      else if (step_a)      cnt_a <= cnt_a + 10'd1;

      if (start_b || ovf_b) cnt_b <= i_TB_VAL;
      else if (step_b)      cnt_b <= cnt_b + 8'd1;

      if (sample_tick) pre_b <= pre_b + 4'd1;

      if (i_FRST_A)                  o_TIMERA_FLAG <= 1'b0;
      else if (ovf_a && i_IRQEN_A)   o_TIMERA_FLAG <= 1'b1;

      if (i_FRST_B)                  o_TIMERB_FLAG <= 1'b0;
      else if (ovf_b && i_IRQEN_B)   o_TIMERB_FLAG <= 1'b1;

      // Overflows only happen on sample ticks, so this holds key-on for one sample.
      if (sample_tick) o_CSM_KEYON <= ovf_a & i_CSM;
    end
  end

  assign o_IRQ_n = ~(o_TIMERA_FLAG | o_TIMERB_FLAG);

endmodule

// File: tb/tb_ika2151_timer.sv
// Scoreboard bench for ika2151_timer: directed scenarios push expected output
// states, a negedge monitor pops and compares them against the DUT pins.
module tb_ika2151_timer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ncenN;
  logic       cyc31;
  logic [9:0] taVal;
  logic [7:0] tbVal;
  logic       loadA, loadB, irqenA, irqenB, frstA, frstB, csm;
  logic       flagA, flagB, irqN, keyOn;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } chk_t;

  chk_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   phase      = 0;
  int   sampleCount = 0;

  ika2151_timer dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rstN),
    .i_phi1_NCEN_n (ncenN),
    .i_CYCLE_31    (cyc31),
    .i_TA_VAL      (taVal),
    .i_TB_VAL      (tbVal),
    .i_LOAD_A      (loadA),
    .i_LOAD_B      (loadB),
    .i_IRQEN_A     (irqenA),
    .i_IRQEN_B     (irqenB),
    .i_FRST_A      (frstA),
    .i_FRST_B      (frstB),
    .i_CSM         (csm),
    .o_TIMERA_FLAG (flagA),
    .o_TIMERB_FLAG (flagB),
    .o_IRQ_n       (irqN),
    .o_CSM_KEYON   (keyOn)
  );

  always #5 clk = ~clk;

  // Monitor: compares the oldest pending expectation on each falling edge.
  always @(negedge clk) begin
    chk_t e;
    logic [3:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {flagA, flagB, irqN, keyOn};
      compared++;
      if (got !== e.exp) begin
        mismatched++;
        $display("[TB] FAIL %s: got flagA/flagB/irq_n/keyon=%b required %b", e.name, got, e.exp);
      end
    end
  end

  // One phi1 tick; CYCLE_31 follows a free-running 32-phase counter.
  task automatic applyStimulus();
    ncenN = 1'b0;
    cyc31 = (phase == 31);
    @(posedge clk);
    #1;
    if (phase == 31) sampleCount++;
    phase = (phase + 1) % 32;
    ncenN = 1'b1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic runSamples(input int n);
    int target;
    target = sampleCount + n;
    while (sampleCount < target) applyStimulus();
  endtask

  task automatic checkOutput(input string name, input logic fa, input logic fb,
                             input logic irq, input logic ko);
    chk_t e;
    e.name = name;
    e.exp  = {fa, fb, irq, ko};
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0; ncenN = 1'b1; cyc31 = 1'b0;
    taVal = '0; tbVal = '0;
    loadA = 0; loadB = 0; irqenA = 0; irqenB = 0; frstA = 0; frstB = 0; csm = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 1, 0);
    rstN = 1'b1;

    $display("[TB] Timer A basic period and flag reset");
    taVal = 10'h3FC; irqenA = 1; loadA = 1;
    applyStimulus();
    runSamples(3);
    checkOutput("a_before_ovf", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("a_ovf_flag", 1, 0, 0, 0);
    frstA = 1; applyStimulus(); frstA = 0;
    checkOutput("a_frst", 0, 0, 1, 0);
    runSamples(3);
    checkOutput("a_reload_before", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("a_reload_ovf", 1, 0, 0, 0);

    $display("[TB] Timer A flag reset held across overflow");
    frstA = 1;
    runSamples(4);
    checkOutput("a_frst_beats_ovf", 0, 0, 1, 0);
    frstA = 0;

    $display("[TB] Timer A load toggle restarts full period");
    runSamples(2);
    loadA = 0;
    runSamples(2);
    checkOutput("a_frozen", 0, 0, 1, 0);
    loadA = 1;
    applyStimulus();
    runSamples(3);
    checkOutput("a_restart_full", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("a_restart_ovf", 1, 0, 0, 0);
    loadA = 0; frstA = 1; applyStimulus(); frstA = 0; irqenA = 0;
    checkOutput("a_cleanup", 0, 0, 1, 0);

    $display("[TB] Timer B prescaled period");
    while ((sampleCount % 16) != 0) runSamples(1);
    tbVal = 8'hFE; irqenB = 1; loadB = 1;
    applyStimulus();
    runSamples(31);
    checkOutput("b_before_ovf", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("b_ovf_flag", 0, 1, 0, 0);
    frstB = 1; applyStimulus(); frstB = 0; irqenB = 0;
    checkOutput("b_frst", 0, 0, 1, 0);
    runSamples(32);
    checkOutput("b_irqen_off", 0, 0, 1, 0);
    irqenB = 1;
    runSamples(31);
    checkOutput("b_reload_before", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("b_reload_ovf", 0, 1, 0, 0);

    $display("[TB] Asynchronous reset mid-count");
    taVal = 10'h3FF; irqenA = 1; loadA = 1;
    applyStimulus();
    runSamples(1);
    checkOutput("both_flags", 1, 1, 0, 0);
    rstN = 1'b0;
    checkOutput("async_reset", 0, 0, 1, 0);
    loadA = 0; loadB = 0;
    rstN = 1'b1;
    runSamples(2);
    checkOutput("idle_after_reset", 0, 0, 1, 0);

    $display("[TB] CSM key-on");
    irqenA = 0; irqenB = 0; csm = 1; taVal = 10'h3FF; loadA = 1;
    applyStimulus();
    runSamples(1);
    checkOutput("csm_keyon", 0, 0, 1, 1);
    runTicks(16);
    checkOutput("csm_mid_sample", 0, 0, 1, 1);
    runSamples(1);
    checkOutput("csm_continuous", 0, 0, 1, 1);
    csm = 0;
    runTicks(31);
    checkOutput("csm_off_pending", 0, 0, 1, 1);
    applyStimulus();
    checkOutput("csm_off_drop", 0, 0, 1, 0);

    $display("[TB] Clock enable held off");
    irqenA = 1; csm = 1;
    for (int i = 0; i < 200; i++) begin
      ncenN = 1'b1;
      cyc31 = ~cyc31;
      @(posedge clk);
      #1;
    end
    cyc31 = 1'b0;
    checkOutput("ncen_hold", 0, 0, 1, 0);
    runSamples(1);
    checkOutput("ncen_resume", 1, 0, 0, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ika2151_timer.md
# ika2151_timer

Timer A / Timer B block of the IKA2151 core: two free-running sample-rate timers with overflow flags, an IRQ output, and a CSM key-on strobe. It sits directly downstream of the timing generator. It advances on that block's phi1 negative-edge clock enable and uses its cycle-31 decode as the once-per-sample tick. Register values arrive from the bus/register block, and the flags are read back through the status byte.

## Interface
Parameters: none.
- i_EMUCLK  in  1  emulator master clock; all state changes on its rising edge
- i_MRST_n  in  1  reset, asynchronous, active-low
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active-low; gates every non-reset update
- i_CYCLE_31  in  1  high for one phi1 cycle in every 32 (one sample)
- i_TA_VAL  in  10  Timer A preset (regs 0x10/0x11)
- i_TB_VAL  in  8  Timer B preset (reg 0x12)
- i_LOAD_A, i_LOAD_B  in  1  run levels (reg 0x14 b0/b1)
- i_IRQEN_A, i_IRQEN_B  in  1  flag-set enables (reg 0x14 b2/b3)
- i_FRST_A, i_FRST_B  in  1  flag-reset requests (reg 0x14 b4/b5), level, sampled on ticks
- i_CSM  in  1  CSM mode enable (reg 0x14 b7)
- o_TIMERA_FLAG, o_TIMERB_FLAG  out  1  overflow flags, to status byte
- o_IRQ_n  out  1  interrupt, active-low
- o_CSM_KEYON  out  1  CSM key-on request to the key-on/EG logic

## Operation
- The block has one clock, i_EMUCLK. Reset is asynchronous and active-low on i_MRST_n.
- Tick: rising i_EMUCLK edge with i_phi1_NCEN_n=0. Sample tick: a tick with i_CYCLE_31=1. Nothing changes outside ticks.
- Load edge: at each tick, i_LOAD_A is registered into `lda_d`. A tick with i_LOAD_A=1 and lda_d=0 is a Timer A start. Timer B uses i_LOAD_B and `ldb_d` the same way.
- Timer A, 10-bit counter `cnt_a`:
  - Start: cnt_a <= i_TA_VAL. This takes priority over any coincident sample tick.
  - Otherwise, at a sample tick with i_LOAD_A=1: if cnt_a==0x3FF, then cnt_a <= i_TA_VAL and an overflow event is raised. Else cnt_a+1.
  - With i_LOAD_A=0, cnt_a holds.
  - Period is 1024-TA_VAL samples. TA_VAL=0x3FF gives an overflow every sample.
- Timer B:
  - A 4-bit prescaler `pre_b` increments at every sample tick regardless of i_LOAD_B, and wraps 15 to 0.
  - The B step is a sample tick with pre_b==15.
  - 8-bit `cnt_b` follows the same rules as Timer A: start loads i_TB_VAL, steps occur only while i_LOAD_B=1, and 0xFF overflows and reloads.
  - Period is 16*(256-TB_VAL) samples. The first period after a start is shortened by the prescaler phase.
- Flags, per timer:
  - At a tick with FRST=1: flag <= 0. Reset beats a coincident overflow.
  - Else if overflow and IRQEN=1: flag <= 1.
  - Else the flag holds.
  - An overflow with IRQEN=0 never sets the flag. Clearing IRQEN does not clear the flag.
- o_IRQ_n = ~(o_TIMERA_FLAG | o_TIMERB_FLAG), combinational from the flag registers.
- CSM:
  - A Timer A overflow with i_CSM=1 sets o_CSM_KEYON=1 for exactly 32 phi1 ticks. It clears at the next sample tick that has no new qualifying overflow.
  - A Timer A overflow with i_CSM=0 does not affect o_CSM_KEYON.
  - o_CSM_KEYON is independent of the flags and IRQEN.

## Timing
- Reset values: cnt_a=0, cnt_b=0, pre_b=0, lda_d=ldb_d=0, both flags 0, o_IRQ_n=1, o_CSM_KEYON=0.
- Reset is asynchronous and takes effect immediately, also mid-count.
- Load latency: cnt_a is valid on the edge of the first tick that sees LOAD=1.
- Overflow latency: the flag and o_CSM_KEYON are valid after the same sample-tick edge on which the counter reloads. o_IRQ_n follows in the same EMUCLK cycle.
- Changes to TA_VAL/TB_VAL while running take effect only at the next reload or start.
- Clearing LOAD while running freezes the counter. Setting LOAD again reloads the preset; the count does not resume from the frozen value.
- Simultaneous start and overflow on one timer: the start wins and no overflow event is raised.
- Timer A and Timer B overflowing on the same tick set both flags independently.

## Test plan
- Reset, then LOAD_A=1, IRQEN_A=1, TA_VAL=0x3FC -> TIMERA_FLAG rises at the 4th sample tick after start and o_IRQ_n goes 0. FRST_A pulse on one tick -> flag 0, o_IRQ_n 1; the next overflow comes 4 samples after the reload.
- TB_VAL=0xFE, LOAD_B=1 asserted with pre_b=0, IRQEN_B=1 -> TIMERB_FLAG set on the 32nd sample tick after start. Repeat with IRQEN_B=0 -> flag stays 0 and the counter still reloads to 0xFE.
- TA_VAL=0x3FF, CSM=1, IRQEN_A=0 -> o_CSM_KEYON stays high continuously, TIMERA_FLAG stays 0, o_IRQ_n stays 1. Set CSM=0 -> o_CSM_KEYON drops at the next sample tick.
- FRST_A=1 held while overflow occurs with IRQEN_A=1 -> flag remains 0. LOAD_A toggled 1→0→1 mid-count -> cnt_a reloads TA_VAL and the period restarts in full.
- Assert i_MRST_n=0 mid-count with both flags set -> all outputs at reset values immediately, without any tick. After release, the timers stay idle until a new load edge.
- Hold i_phi1_NCEN_n=1 with CYCLE_31 toggling -> no counter, prescaler or flag change.
